vpipe_delay_chain: RTL and testbench
====================================

// Module: vpipe_delay_chain
// PURPOSE
//  Parametrised, stallable, flushable delay chain that carries a control word, a dest-register tag and
//  LANES-wide vector data through DEPTH register stages with per-stage valid bits and bubble collapsing.
//  Replaces the hand-instantiated fixed 9-deep vector-execute control chain and per-lane data registers.
//  Sits between vector decode/issue and vector writeback; provides a registered occupancy count and a
//  tag hazard query for the issue stage.
// PARAMETERS
//  DEPTH   9   number of register stages (>=1); empty-pipe latency in cycles
//  LANES   4   vector lanes carried per entry
//  WIDTH   32  bits per lane
//  CTRL_W  64  width of packed control word
//  TAG_W   5   width of destination-register tag
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 synchronous active-low reset
//  in_valid   in   1                 upstream entry present
//  in_ready   out  1                 stage 0 can load this cycle (= move[0] && !flush)
//  in_ctrl    in   CTRL_W            control word
//  in_tag     in   TAG_W             destination register tag
//  in_data    in   LANES x WIDTH     lane data
//  stall      in   1                 freeze every stage (valid and payload)
//  flush      in   1                 invalidate every stage
//  out_valid  out  1                 last stage valid
//  out_ready  in   1                 writeback consumes last stage
//  out_ctrl   out  CTRL_W            last-stage control
//  out_tag    out  TAG_W             last-stage tag
//  out_data   out  LANES x WIDTH     last-stage data
//  occupancy  out  $clog2(DEPTH+1)   registered count of valid stages
//  q_tag      in   TAG_W             hazard query tag
//  q_hit      out  1                 comb: some valid stage holds tag == q_tag
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): all valid bits 0, occupancy 0, payload regs 0; out_* read 0.
//  - move[DEPTH-1] = !stall && (!v[DEPTH-1] || out_ready); move[k] = !stall && (!v[k] || move[k+1]).
//  - On move[k]: v[k] <= v[k-1] (stage -1 = in_valid && in_ready); payload loads only if source valid.
//  - !move[k]: stage holds. A bubble at stage k is filled while stages above it hold.
//  - Latency: empty pipe, no stall, out_ready=1: entry accepted at edge t gives out_valid at edge t+DEPTH-1.
//  - Throughput 1 entry/cycle at steady state; out_ready low at a full pipe gives in_ready low in the same cycle.
//  - flush: highest priority over stall. All v <= 0, occupancy <= 0 next edge. in_ready=0 that cycle.
//    out_valid is still visible that cycle, but no handshake is counted.
//  - occupancy: +1 on input handshake, -1 on output handshake (out_valid && out_ready && !stall),
//    net 0 on both; must equal popcount(v) every cycle.
//  - q_hit ignores invalid stages; the input-side entry is not compared.
//  - DEPTH==1: single stage; in_ready = !stall && (!v[0] || out_ready) && !flush.
// CONFIGURATION
//  - VPIPE_TAP_EN defined: adds outputs tap_valid[DEPTH] and tap_tag[DEPTH][TAG_W] (raw stage state)
//    for forwarding/scoreboard logic.
//  - VPIPE_TAP_EN undefined: ports absent, behaviour otherwise identical.
// STRUCTURE
//  - vpipe_pkg holds: lane_vec_t (LANES x WIDTH), tag_t, vpipe_entry_t struct {ctrl, tag, data}, VPIPE_DEPTH_DEF.
//  - Sub-module vpipe_stage: one valid + entry register with load enable and sync clear (flush/reset).
//    Instantiated DEPTH times via generate; move chain and occupancy counter live in the top.
// TESTING (DEPTH=9, LANES=4)
//  - Stream 20 entries (tags 0..19), out_ready=1, no stall -> out order 0..19, first out 8 cycles after accept, no gaps.
//  - Fill 9, out_ready=0 -> in_ready=0, occupancy=9; out_ready=1 one cycle -> exactly one drain.
//  - Bubble collapse: entries at cycles 0 and 3, out_ready=0 -> both adjacent in stages 8,7; occupancy=2.
//  - stall=1 for 5 cycles mid-stream -> no v/payload change, occupancy constant; resume yields order intact.
//  - flush with occupancy=6 and in_valid=1 -> next cycle occupancy=0, out_valid=0, flushed input never appears.
//  - q_tag=7 while tag 7 is in stage 4 -> q_hit=1; after it drains -> q_hit=0; reset mid-stream -> all zero next edge.

Source files
------------

// File: rtl/vpipe_pkg.sv
// Shared types for the vector-execute delay chain.
// Default geometry matches the 9-deep, 4-lane x 32-bit execute pipe.
package vpipe_pkg;

  localparam int VPIPE_DEPTH_DEF = 9;
  localparam int VPIPE_LANES     = 4;
  localparam int VPIPE_WIDTH     = 32;
  localparam int VPIPE_CTRL_W    = 64;
  localparam int VPIPE_TAG_W     = 5;

  typedef logic [VPIPE_LANES-1:0][VPIPE_WIDTH-1:0] lane_vec_t;
  typedef logic [VPIPE_TAG_W-1:0]                  tag_t;

  typedef struct packed {
    logic [VPIPE_CTRL_W-1:0] ctrl;
    tag_t                    tag;
    lane_vec_t               data;
  } vpipe_entry_t;

endpackage

// File: rtl/vpipe_stage.sv
// One delay-chain stage: valid bit plus entry register.
// Clear (flush or reset) wins over load; payload only loads with a valid source.
module vpipe_stage
  import vpipe_pkg::*;
#(
  parameter type entry_t = vpipe_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   load,
  input  logic   src_valid,
  input  entry_t src,
  output logic   valid,
  output entry_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) q <= src;
    end
  end

endmodule

// File: rtl/vpipe_delay_chain.sv
// Stallable, flushable vector-execute delay chain with bubble collapsing.
// Define VPIPE_TAP_EN to expose per-stage valid/tag taps.
module vpipe_delay_chain
  import vpipe_pkg::*;
#(
  parameter int DEPTH  = VPIPE_DEPTH_DEF,
  parameter int LANES  = VPIPE_LANES,
  parameter int WIDTH  = VPIPE_WIDTH,
  parameter int CTRL_W = VPIPE_CTRL_W,
  parameter int TAG_W  = VPIPE_TAG_W,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [LANES-1:0][WIDTH-1:0] in_data,
  input  logic                        stall,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [TAG_W-1:0]            out_tag,
  output logic [LANES-1:0][WIDTH-1:0] out_data,
  output logic [OW-1:0]               occupancy,
`ifdef VPIPE_TAP_EN
  output logic [DEPTH-1:0]            tap_valid,
  output logic [DEPTH-1:0][TAG_W-1:0] tap_tag,
`endif
  input  logic [TAG_W-1:0]            q_tag,
  output logic                        q_hit
);

  typedef struct packed {
    logic [CTRL_W-1:0]           ctrl;
    logic [TAG_W-1:0]            tag;
    logic [LANES-1:0][WIDTH-1:0] data;
  } entry_t;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] mv;
  entry_t           st [DEPTH];
  entry_t           in_e;
  logic             acc;
  logic             drn;

  // Move chain resolved from the output end back toward the input.
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = !stall && (!v[DEPTH-1] || out_ready);
    for (int k = DEPTH - 2; k >= 0; k--) begin
      mv[k] = !stall && (!v[k] || mv[k+1]);
    end
  end

  assign in_ready = mv[0] && !flush;
  assign acc      = in_valid && in_ready;
  assign drn      = out_valid && out_ready && !stall && !flush;
  assign in_e     = '{ctrl: in_ctrl, tag: in_tag, data: in_data};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      vpipe_stage #(.entry_t(entry_t)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .load     (mv[k]),
        .src_valid(acc),
        .src      (in_e),
        .valid    (v[k]),
        .q        (st[k])
      );
    end else begin : g_body
      vpipe_stage #(.entry_t(entry_t)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .load     (mv[k]),
        .src_valid(v[k-1]),
        .src      (st[k-1]),
        .valid    (v[k]),
        .q        (st[k])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      occupancy <= '0;
    end else begin
      unique case ({acc, drn})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_comb begin
    q_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v[k] && st[k].tag == q_tag) q_hit = 1'b1;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_ctrl  = st[DEPTH-1].ctrl;
  assign out_tag   = st[DEPTH-1].tag;
  assign out_data  = st[DEPTH-1].data;

`ifdef VPIPE_TAP_EN
  always_comb begin
    tap_valid = v;
    for (int k = 0; k < DEPTH; k++) tap_tag[k] = st[k].tag;
  end
`endif

endmodule

// File: tb/tb_vpipe_delay_chain.sv
// Directed bench for vpipe_delay_chain at DEPTH=9, LANES=4.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_vpipe_delay_chain;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_ctrl;
  logic [4:0]        in_tag;
  logic [3:0][31:0]  in_data;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_ctrl;
  logic [4:0]        out_tag;
  logic [3:0][31:0]  out_data;
  logic [3:0]        occupancy;
  logic [4:0]        q_tag;
  logic              q_hit;
`ifdef VPIPE_TAP_EN
  logic [8:0]        tap_valid;
  logic [8:0][4:0]   tap_tag;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  vpipe_delay_chain #(
    .DEPTH(9), .LANES(4), .WIDTH(32), .CTRL_W(64), .TAG_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_tag   (in_tag),
    .in_data  (in_data),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_tag  (out_tag),
    .out_data (out_data),
    .occupancy(occupancy),
`ifdef VPIPE_TAP_EN
    .tap_valid(tap_valid),
    .tap_tag  (tap_tag),
`endif
    .q_tag    (q_tag),
    .q_hit    (q_hit)
  );

  function automatic logic [63:0] ctrl_of(input logic [4:0] t);
    return {32'hC0DE_0000, 27'd0, t};
  endfunction

  function automatic logic [3:0][31:0] data_of(input logic [4:0] t);
    logic [3:0][31:0] d;
    for (int l = 0; l < 4; l++) d[l] = {16'hDA7A, 8'(l), 3'd0, t};
    return d;
  endfunction

  task automatic push(input logic [4:0] t);
    in_valid = 1'b1;
    in_tag   = t;
    in_ctrl  = ctrl_of(t);
    in_data  = data_of(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_tag = '0;
    in_data = '0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    q_tag = '0;
    repeat (2) step();
    vecs++;
    if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
      errs++;
      $display("FAIL reset_state: out_valid=%b occ=%0d, want 0 0",
               out_valid, occupancy);
    end
    vecs++;
    if (out_tag !== 5'd0 || out_ctrl !== 64'd0 || out_data !== '0) begin
      errs++;
      $display("FAIL reset_payload: tag=%0d ctrl=%h, want 0 0",
               out_tag, out_ctrl);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) push(5'(c));
      else in_valid = 1'b0;
      step();
      vecs++;
      if (out_valid !== (c >= 8 && c <= 27)) begin
        errs++;
        $display("FAIL stream_valid c=%0d: got %b want %b",
                 c, out_valid, (c >= 8 && c <= 27));
      end
      if (c >= 8 && c <= 27) begin
        vecs++;
        if (out_tag !== 5'(c - 8) || out_ctrl !== ctrl_of(5'(c - 8)) ||
            out_data !== data_of(5'(c - 8))) begin
          errs++;
          $display("FAIL stream_order c=%0d: tag %0d want %0d",
                   c, out_tag, c - 8);
        end
      end
    end
    vecs++;
    if (occupancy !== 4'd0) begin
      errs++;
      $display("FAIL stream_empty: occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(5'(10 + i));
      step();
    end
    push(5'd19);
    #1;
    vecs++;
    if (in_ready !== 1'b0 || occupancy !== 4'd9) begin
      errs++;
      $display("FAIL fill_full: in_ready=%b occ=%0d want 0 9",
               in_ready, occupancy);
    end
    vecs++;
    if (out_valid !== 1'b1 || out_tag !== 5'd10) begin
      errs++;
      $display("FAIL fill_head: v=%b tag=%0d want 1 10", out_valid, out_tag);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++;
    if (occupancy !== 4'd8 || out_tag !== 5'd11) begin
      errs++;
      $display("FAIL fill_one_drain: occ=%0d tag=%0d want 8 11",
               occupancy, out_tag);
    end
    step();
    vecs++;
    if (occupancy !== 4'd8 || out_tag !== 5'd11 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL fill_hold: occ=%0d tag=%0d want 8 11",
               occupancy, out_tag);
    end
    drain();
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    push(5'd21);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    push(5'd22);
    step();
    in_valid = 1'b0;
    repeat (12) step();
    vecs++;
    if (occupancy !== 4'd2 || out_valid !== 1'b1 || out_tag !== 5'd21) begin
      errs++;
      $display("FAIL bubble_head: occ=%0d v=%b tag=%0d want 2 1 21",
               occupancy, out_valid, out_tag);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vecs++;
    if (occupancy !== 4'd1 || out_valid !== 1'b1 || out_tag !== 5'd22) begin
      errs++;
      $display("FAIL bubble_adjacent: occ=%0d v=%b tag=%0d want 1 1 22",
               occupancy, out_valid, out_tag);
    end
    drain();
  endtask

  task automatic test_stall();
    int         sent = 0;
    int         rcvd = 0;
    logic       hs_in, hs_out, snap_v;
    logic [4:0] ot, snap_tag;
    logic [3:0] snap_occ;
    snap_v = 1'b0; snap_tag = '0; snap_occ = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      stall = (c >= 12 && c < 17);
      if (c == 12) begin
        snap_occ = occupancy;
        snap_tag = out_tag;
        snap_v   = out_valid;
      end
      if (sent < 16) push(5'(sent));
      else in_valid = 1'b0;
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready && !stall;
      ot     = out_tag;
      step();
      if (hs_in) sent++;
      if (hs_out) begin
        vecs++;
        if (ot !== 5'(rcvd)) begin
          errs++;
          $display("FAIL stall_order: got %0d want %0d", ot, rcvd);
        end
        rcvd++;
      end
      if (stall) begin
        vecs++;
        if (occupancy !== snap_occ || out_tag !== snap_tag ||
            out_valid !== snap_v) begin
          errs++;
          $display("FAIL stall_freeze c=%0d: occ=%0d tag=%0d want %0d %0d",
                   c, occupancy, out_tag, snap_occ, snap_tag);
        end
      end
    end
    stall = 1'b0;
    vecs++;
    if (rcvd !== 16 || occupancy !== 4'd0) begin
      errs++;
      $display("FAIL stall_total: rcvd=%0d occ=%0d want 16 0",
               rcvd, occupancy);
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(5'(1 + i));
      step();
    end
    vecs++;
    if (occupancy !== 4'd6) begin
      errs++;
      $display("FAIL flush_pre_occ: got %0d want 6", occupancy);
    end
    push(5'd30);
    flush = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    vecs++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_clear: occ=%0d v=%b want 0 0",
               occupancy, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL flush_ghost: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_qhit();
    out_ready = 1'b1;
    q_tag = 5'd7;
    push(5'd7);
    #1;
    vecs++;
    if (q_hit !== 1'b0) begin
      errs++;
      $display("FAIL qhit_input_side: got %b want 0", q_hit);
    end
    step();
    in_valid = 1'b0;
    repeat (4) step();
    vecs++;
    if (q_hit !== 1'b1) begin
      errs++;
      $display("FAIL qhit_stage4: got %b want 1", q_hit);
    end
    q_tag = 5'd8;
    #1;
    vecs++;
    if (q_hit !== 1'b0) begin
      errs++;
      $display("FAIL qhit_other_tag: got %b want 0", q_hit);
    end
    q_tag = 5'd7;
    repeat (8) step();
    vecs++;
    if (q_hit !== 1'b0) begin
      errs++;
      $display("FAIL qhit_drained: got %b want 0", q_hit);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(5'(1 + i));
      step();
    end
    in_valid = 1'b0;
    q_tag    = 5'd1;
    rst_n    = 1'b0;
    step();
    vecs++;
    if (occupancy !== 4'd0 || out_valid !== 1'b0 || q_hit !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_state: occ=%0d v=%b hit=%b want 0 0 0",
               occupancy, out_valid, q_hit);
    end
    vecs++;
    if (out_tag !== 5'd0 || out_ctrl !== 64'd0 || out_data !== '0) begin
      errs++;
      $display("FAIL reset_mid_payload: tag=%0d ctrl=%h want 0 0",
               out_tag, out_ctrl);
    end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_bubble();
    test_stall();
    test_flush();
    test_qhit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
